// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use bubbles, redirect squashes and
// multi-cycle MDU front-end freeze, with a saturating stall/flush counter.
module hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegWrite,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        ex_mdu_op,
  output logic        pc_pause,
  output logic        ifid_pause,
  output logic        ifid_flush,
  output logic        idex_hold,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   mdu_cnt_reg;
  logic [31:0]        stall_cnt_reg;

  logic [1:0]         src_hit;
  logic               ldu;
  logic               any_stall;

  // One comparator per source operand of the ID instruction.
  logic [4:0] id_src [2];
  logic [1:0] id_use;
  assign id_src[0] = id_rs1;
  assign id_src[1] = id_rs2;
  assign id_use    = {id_use_rs2, id_use_rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = id_use[gi] && (id_src[gi] == ex_rd);
    end
  endgenerate

  // x0 is never a real producer, so it cannot create a dependency.
  assign ldu = ex_is_load && ex_RegWrite && (ex_rd != 5'd0) && (|src_hit);

  always_comb begin
    pc_pause    = 1'b0;
    ifid_pause  = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    if (!rst) begin
      case (state_reg)
        RUN: begin
          if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mdu_op) begin
            pc_pause    = 1'b1;
            ifid_pause  = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            mdu_busy    = 1'b1;
          end else if (ldu) begin
            pc_pause   = 1'b1;
            ifid_pause = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          // Last occupancy cycle: release everything so the result reaches MEM.
          if (mdu_cnt_reg == '0) begin
            mdu_done = 1'b1;
          end else begin
            pc_pause    = 1'b1;
            ifid_pause  = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            mdu_busy    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign any_stall = pc_pause | ifid_flush | idex_flush | exmem_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      mdu_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (any_stall && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      case (state_reg)
        RUN: begin
          if (!ex_redirect && ex_mdu_op) begin
            state_reg   <= MDU_WAIT;
            mdu_cnt_reg <= CNT_W'(MDU_LAT - 2);
          end
        end
        MDU_WAIT: begin
          if (mdu_cnt_reg == '0)
            state_reg <= RUN;
          else
            mdu_cnt_reg <= mdu_cnt_reg - 1'b1;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LAT=4); expected controls and counter
// values are queued per step and checked mid-cycle.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_RegWrite, ex_is_load, ex_redirect, ex_mdu_op;
  logic        pc_pause, ifid_pause, ifid_flush, idex_hold, idex_flush, exmem_flush;
  logic        mdu_busy, mdu_done;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .ex_mdu_op(ex_mdu_op),
    .pc_pause(pc_pause), .ifid_pause(ifid_pause), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
  );

  // {pc_pause, ifid_pause, ifid_flush, idex_hold, idex_flush, exmem_flush, mdu_busy, mdu_done}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LDU  = 8'b1100_1000;
  localparam logic [7:0] C_RDR  = 8'b0010_1000;
  localparam logic [7:0] C_MDU  = 8'b1101_0110;
  localparam logic [7:0] C_DONE = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_cnt = 32'd0;
  int          tests = 0;
  int          fails = 0;

  task automatic step(input string tag, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic rdr, input logic mdu,
                      input logic [7:0] exp_ctl);
    exp_t       e;
    logic [7:0] obs;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_RegWrite = rw; ex_is_load = ld; ex_redirect = rdr; ex_mdu_op = mdu;
    sb_q.push_back('{ctl: exp_ctl, cnt: model_cnt});
    #4;
    e   = sb_q.pop_front();
    obs = {pc_pause, ifid_pause, ifid_flush, idex_hold, idex_flush, exmem_flush, mdu_busy, mdu_done};
    tests++;
    assert (obs === e.ctl) else begin
      fails++;
      $error("FAIL %s ctl: got %b expected %b", tag, obs, e.ctl);
    end
    tests++;
    assert (stall_cnt === e.cnt) else begin
      fails++;
      $error("FAIL %s stall_cnt: got %h expected %h", tag, stall_cnt, e.cnt);
    end
    $display("[TB] %s ctl=%b cnt=%h", tag, obs, stall_cnt);
    if (r)
      model_cnt = 32'd0;
    else if ((exp_ctl[7] | exp_ctl[5] | exp_ctl[3] | exp_ctl[2]) && model_cnt != 32'hFFFF_FFFF)
      model_cnt = model_cnt + 32'd1;
  endtask

  task automatic idle(input string tag, input logic [7:0] exp_ctl);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_ctl);
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_RegWrite = 0; ex_is_load = 0; ex_redirect = 0; ex_mdu_op = 0;
    repeat (2) @(posedge clk);

    // Reset state, with a hazard pattern on the inputs that must be masked.
    step("reset", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, C_NONE);
    idle("idle0", C_NONE);

    // Load-use hazards and non-hazards.
    step("ldu_rs1", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU);
    idle("after_ldu", C_NONE);
    step("ldu_x0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE);
    step("rs2_nouse", 1'b0, 5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE);
    step("ldu_rs2", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU);
    step("load_nowr", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE);
    step("notload", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE);

    // Redirect wins over a simultaneous load-use and over an MDU op.
    step("redir_ldu", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_RDR);
    step("redir_mdu", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_RDR);
    idle("after_redir", C_NONE);

    // MDU sequencing, MDU_LAT=4.
    step("mdu_t0", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MDU);
    idle("mdu_t1", C_MDU);
    idle("mdu_t2", C_MDU);
    idle("mdu_t3", C_DONE);
    idle("mdu_t4", C_NONE);

    // MDU ignores redirect / load-use / new MDU requests while busy.
    step("mduev_t0", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MDU);
    step("mduev_t1", 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, C_MDU);
    step("mduev_t2", 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, C_MDU);
    step("mduev_t3", 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, C_DONE);
    idle("mduev_t4", C_NONE);

    // Reset in the middle of an MDU op.
    step("mdurst_t0", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MDU);
    step("mdurst_t1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
    step("mdurst_t2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
    idle("mdurst_t3", C_NONE);
    idle("mdurst_t4", C_NONE);

    // Saturation: preload counter near the top, then stall.
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    model_cnt = 32'hFFFF_FFFE;
    step("sat_0", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU);
    step("sat_1", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU);
    step("sat_2", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LDU);
    idle("sat_end", C_NONE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. It drives the pause, hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards, squashes wrong-path instructions on EX-resolved redirects, and freezes the front end while a multi-cycle mul/div op occupies EX.
- Keeps a saturating stall/flush performance counter.

Parameters:
- MDU_LAT, 32, total EX occupancy in cycles of a multi-cycle mul/div op (legal range 2..63).
- CNT_W, 6, width of the internal MDU down-counter; must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_RegWrite  in  1  EX instruction writes the GPR file
- ex_is_load  in  1  EX instruction is a load (WDsel = memory)
- ex_redirect  in  1  EX resolved a taken branch or jump (NPC differs from PC+4)
- ex_mdu_op  in  1  EX instruction is a multi-cycle mul/div
- pc_pause  out  1  hold the PC
- ifid_pause  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID
- idex_hold  out  1  ID/EX keeps its current contents
- idex_flush  out  1  load a bubble into ID/EX (all controls zero)
- exmem_flush  out  1  load a bubble into EX/MEM
- mdu_busy  out  1  MDU occupancy in progress
- mdu_done  out  1  one-cycle pulse in the last MDU cycle; the EX result is valid
- stall_cnt  out  32  count of cycles in which any pause or flush output was asserted

Behaviour:
- Outputs are combinational from state and inputs (Mealy). State, counter and stall_cnt are registered.
- FSM states: RUN, MDU_WAIT.
- Reset: state=RUN, mdu_cnt=0, stall_cnt=0. While rst is high, every control output is 0. Reset mid-MDU abandons the op immediately.
- Load-use hazard (ldu), evaluated only in RUN:
  - ldu = ex_is_load & ex_RegWrite & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN: ex_redirect > ex_mdu_op > ldu.
- RUN with ex_redirect: ifid_flush=1, idex_flush=1, no pauses. Stay in RUN. Any concurrent ldu is ignored, because the ID instruction is wrong-path.
- RUN with ex_mdu_op (and no redirect):
  - Outputs: pc_pause=1, ifid_pause=1, idex_hold=1, exmem_flush=1, mdu_busy=1.
  - Next state MDU_WAIT, mdu_cnt <= MDU_LAT-2.
  - The first cycle counts as occupancy cycle 1.
- RUN with ldu only: pc_pause=1, ifid_pause=1, idex_flush=1. This inserts exactly one bubble. Next cycle the load is in MEM and forwarding resolves the dependency.
- RUN with nothing active: all outputs 0.
- MDU_WAIT:
  - Outputs: pc_pause=1, ifid_pause=1, idex_hold=1, exmem_flush=1, mdu_busy=1.
  - mdu_cnt decrements by 1 each cycle.
  - When mdu_cnt==0: mdu_done=1; idex_hold, exmem_flush, pc_pause and ifid_pause are all 0 that cycle, so the result advances to MEM; next state RUN.
  - Total EX occupancy is exactly MDU_LAT cycles; mdu_busy is high for MDU_LAT-1 cycles.
- ex_redirect, ex_mdu_op and ldu are ignored in MDU_WAIT, since EX holds the MDU op.
- idex_hold and idex_flush are never both 1. ID/EX gives idex_flush precedence in any case.
- stall_cnt increments when (pc_pause | ifid_flush | idex_flush | exmem_flush) in a non-reset cycle. It saturates at 0xFFFFFFFF and does not wrap.
- x0 rule: ex_rd==0 never triggers ldu.

Test Plan:
- ldu basic: EX lw x5 (ex_is_load=1, ex_RegWrite=1, ex_rd=5); ID add reading rs1=5 (use_rs1=1). Required: pc_pause=ifid_pause=idex_flush=1 for exactly 1 cycle, then all 0; stall_cnt=1.
- ldu x0 and non-use cases: same as ldu basic with ex_rd=0, or with id_rs2=5 and use_rs2=0. Required: no stall asserted; stall_cnt unchanged.
- Redirect beats ldu: ex_redirect=1 together with a matching load-use pattern. Required: ifid_flush=idex_flush=1, pc_pause=0, for 1 cycle.
- MDU sequencing, MDU_LAT=4: ex_mdu_op=1 at cycle t. Required: mdu_busy=1 at cycles t..t+2; mdu_done=1 only at t+3; idex_hold=1 at t..t+2 and 0 at t+3; back in RUN at t+4; stall_cnt=3.
- MDU ignores events: during MDU_WAIT, drive ex_redirect=1 and a matching ldu. Required: outputs identical to the MDU sequencing case.
- Reset mid-MDU: rst=1 at t+1 of the MDU sequencing case. Required: all outputs 0 and stall_cnt=0 during and after reset; state RUN.
- Saturation: preload stall_cnt to 0xFFFFFFFE, then apply 3 stall cycles. Required: stall_cnt holds at 0xFFFFFFFF.
